// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

   // Which core port owns a memory access (grant or pending response).
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_INST = 2'd1,
      SRC_DATA = 2'd2
   } bus_src_t;

   // Arbiter sequencing state.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ARB  = 2'd1,
      ARB_LOCK = 2'd2
   } arb_state_t;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory (1-cycle read latency) between
// the instruction-fetch port and the data port. Data wins by default, a
// streak limit keeps fetch from starving, and bus_lock pins the memory to
// the data port for atomic sequences.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | no access issued last cycle
// ARB_ARB  | an access was issued last cycle, normal arbitration
// ARB_LOCK | data port holds the memory while bus_lock stays high
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 30,
   parameter int DATA_W     = 32,
   parameter int MAX_STREAK = 4
) (
   input  logic                clk,
   input  logic                sync_rst,
   input  logic                clk_en,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_address,
   output logic                inst_ready,
   output logic                inst_valid,
   output logic [DATA_W-1:0]   inst_in,
   input  logic                data_req,
   input  logic                memory_mode,
   input  logic [ADDR_W-1:0]   data_address,
   input  logic [DATA_W/8-1:0] data_mask,
   input  logic [DATA_W-1:0]   data_out,
   input  logic                bus_lock,
   output logic                data_ready,
   output logic                data_valid,
   output logic [DATA_W-1:0]   data_in,
   output logic                mem_en,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int            SW         = $clog2(MAX_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

   arb_state_t    state;
   logic [SW-1:0] streak;
   bus_src_t      resp_src;
   bus_src_t      grant_src;
   logic          locked;
   logic          streak_full;
   logic          grant_inst;
   logic          grant_data;

   // Lock only holds while bus_lock stays high; the cycle it drops is arbitrated normally.
   assign locked      = (state == ARB_LOCK) && bus_lock;
   assign streak_full = (streak == STREAK_MAX);

   // Pick at most one port per cycle; nothing is granted while frozen or in reset.
   always_comb begin
      grant_src = SRC_NONE;
      if (clk_en && !sync_rst) begin
         if (locked) begin
            if (data_req) grant_src = SRC_DATA;
         end else if (data_req && !(inst_req && streak_full)) begin
            grant_src = SRC_DATA;
         end else if (inst_req) begin
            grant_src = SRC_INST;
         end
      end
   end

   assign grant_inst = (grant_src == SRC_INST);
   assign grant_data = (grant_src == SRC_DATA);
   assign inst_ready = grant_inst;
   assign data_ready = grant_data;

   // Steer the winning port onto the memory bus.
   always_comb begin
      mem_en    = grant_inst || grant_data;
      mem_we    = grant_data && (memory_mode != MEM_READ);
      mem_be    = (grant_data && (memory_mode == MEM_WRITE)) ? data_mask : '1;
      mem_addr  = grant_data ? data_address : inst_address;
      mem_wdata = data_out;
   end

   // Arbitration state, starvation streak and response ownership.
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state    <= ARB_IDLE;
         streak   <= '0;
         resp_src <= SRC_NONE;
      end else if (clk_en) begin
         resp_src <= grant_src;

         if (locked || (grant_data && bus_lock)) begin
            state <= ARB_LOCK;
         end else if (grant_src != SRC_NONE) begin
            state <= ARB_ARB;
         end else begin
            state <= ARB_IDLE;
         end

         // Streak is meaningful only while fetch waits; a locked sequence does not count.
         if (!locked) begin
            if (!inst_req || grant_inst) begin
               streak <= '0;
            end else if (grant_data && !streak_full) begin
               streak <= streak + 1'b1;
            end
         end
      end
   end

   // Read data is shared; the valid strobe tells each port whether it is theirs.
   assign inst_valid = (resp_src == SRC_INST);
   assign data_valid = (resp_src == SRC_DATA);
   assign inst_in    = mem_rdata;
   assign data_in    = mem_rdata;

endmodule
